// File: rtl/pipe_queue_pkg.sv
// Shared constants and elaboration helpers for the inter-stage elastic queues.
package pipe_queue_pkg;

    localparam int unsigned DEFAULT_STAGE_WIDTH = 64;
    localparam int unsigned DEFAULT_QUEUE_DEPTH = 2;

    // True for powers of two of at least 2 (legal queue depths).
    function automatic bit is_legal_depth(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Valid almost-full threshold lies in 1..depth.
    function automatic bit is_legal_afull(input int unsigned level, input int unsigned depth);
        return (level >= 1) && (level <= depth);
    endfunction

endpackage

// File: rtl/pipe_queue.sv
// Elastic DEPTH-entry FIFO between adjacent pipeline stages with valid/ready
// handshakes and a synchronous flush for branch redirects.
module pipe_queue
    import pipe_queue_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_STAGE_WIDTH,
    parameter int unsigned DEPTH       = DEFAULT_QUEUE_DEPTH,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (!is_legal_depth(DEPTH)) begin : g_bad_depth
        $fatal(1, "pipe_queue: DEPTH must be a power of two >= 2");
    end
    if (!is_legal_afull(AFULL_LEVEL, DEPTH)) begin : g_bad_afull
        $fatal(1, "pipe_queue: AFULL_LEVEL must be in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;

    // Handshake qualifiers: ready/valid are flops, so no comb path from out_ready to in_ready.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Next-state pointers and occupancy; flush clears everything and drops any push.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // Control state; status outputs are precomputed from the next occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            in_ready    <= (count_next != CNT_W'(DEPTH));
            out_valid   <= (count_next != '0);
            almost_full <= (count_next >= CNT_W'(AFULL_LEVEL));
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_pipe_queue.sv
// Randomised and directed checks of pipe_queue against a queue-based reference model.
module tb_pipe_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFULL = DEPTH - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [2:0]        count;
    logic              almost_full;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [WIDTH-1:0] model_q [$];

    pipe_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare outputs with the model mid-cycle, then advance the model.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic fl, input logic rs);
        int unsigned n;
        logic        do_push;
        logic        do_pop;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(negedge clock);
        n = model_q.size();
        check("count",       64'(count),       64'(n));
        check("in_ready",    64'(in_ready),    64'(n != DEPTH));
        check("out_valid",   64'(out_valid),   64'(n != 0));
        check("almost_full", 64'(almost_full), 64'(n >= AFULL));
        if (n != 0) check("out_data", 64'(out_data), 64'(model_q[0]));
        if (rs || fl) begin
            model_q.delete();
        end else begin
            do_push = iv && (n < DEPTH);
            do_pop  = ordy && (n > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(id);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        @(posedge clock); #1;

        // Reset held with in_valid asserted: nothing may be enqueued.
        step(1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1);

        // Fill to full, attempt a fifth push, then drain.
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming with pointer wrap.
        for (int i = 0; i < 21; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Full with simultaneous pop: pop only, then the held datum is accepted.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hB4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush mid-stream with a push in the flush cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset and flush together while full.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hEE, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                 ($urandom % 25) == 0, ($urandom % 60) == 0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
